// File: rtl/board_input_conditioner.sv
// Board input conditioner: synchronises and debounces the reset button and switches,
// sequences the SoC reset and freezes the switch vector at every reset release.
module board_input_conditioner #(
    parameter int NumIn          = 4,
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 500000,
    parameter int RstHoldCycles  = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             btn_rst_i,
    input  logic [NumIn-1:0] sw_i,
    output logic [NumIn-1:0] sw_o,
    output logic             sw_changed_o,
    output logic [NumIn-1:0] latched_sw_o,
    output logic             soc_rst_no
);

    localparam int NumCh        = NumIn + 1;
    localparam int BtnIdx       = NumIn;
    localparam int DebW         = $clog2(DebounceCycles);
    localparam int SettleCycles = SyncStages + DebounceCycles + 1;
    localparam int FsmMax       = (SettleCycles > RstHoldCycles) ? SettleCycles : RstHoldCycles;
    localparam int FsmW         = (FsmMax > 1) ? $clog2(FsmMax) : 1;

    localparam logic [DebW-1:0] DebLast    = DebW'(DebounceCycles - 1);
    localparam logic [FsmW-1:0] SettleLast = FsmW'(SettleCycles - 1);
    localparam logic [FsmW-1:0] HoldLast   = FsmW'(RstHoldCycles - 1);

    if (SyncStages < 2) begin : g_bad_sync
        $error("SyncStages must be at least 2");
    end
    if (DebounceCycles < 2) begin : g_bad_deb
        $error("DebounceCycles must be at least 2");
    end
    if (RstHoldCycles < 1) begin : g_bad_hold
        $error("RstHoldCycles must be at least 1");
    end

    // Channel NumIn is the reset button; channels below it are the switches.
    logic [NumCh-1:0] raw_ch;
    logic [NumCh-1:0] deb_all;
    logic [NumIn-1:0] sw_deb_next;
    logic             btn_deb;

    assign raw_ch = {btn_rst_i, sw_i};

    for (genvar gi = 0; gi < NumCh; gi++) begin : g_ch
        logic [SyncStages-1:0] sync_q, sync_d;
        logic [DebW-1:0]       cnt_q, cnt_d;
        logic                  deb_q, deb_d;
        logic                  sync_out;

        assign sync_out = sync_q[SyncStages-1];

        always_comb begin
            sync_d = {sync_q[SyncStages-2:0], raw_ch[gi]};
            cnt_d  = '0;
            deb_d  = deb_q;
            if (sync_out != deb_q) begin
                if (cnt_q == DebLast) begin
                    deb_d = sync_out;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                sync_q <= '0;
                cnt_q  <= '0;
                deb_q  <= 1'b0;
            end else begin
                sync_q <= sync_d;
                cnt_q  <= cnt_d;
                deb_q  <= deb_d;
            end
        end

        assign deb_all[gi] = deb_q;
        if (gi < NumIn) begin : g_sw_next
            assign sw_deb_next[gi] = deb_d;
        end
    end

    assign sw_o    = deb_all[NumIn-1:0];
    assign btn_deb = deb_all[BtnIdx];

    typedef enum logic [1:0] {
        INIT = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [FsmW-1:0]  fsm_cnt_q, fsm_cnt_d;
    logic [NumIn-1:0] latched_sw_q, latched_sw_d;
    logic             soc_rst_n_q, soc_rst_n_d;
    logic             sw_changed_q, sw_changed_d;

    // Pulse lines up with the cycle in which the new sw_o value first appears.
    assign sw_changed_d = (sw_deb_next != sw_o);

    always_comb begin
        state_d      = state_q;
        fsm_cnt_d    = fsm_cnt_q;
        latched_sw_d = latched_sw_q;
        soc_rst_n_d  = soc_rst_n_q;
        case (state_q)
            INIT: begin
                soc_rst_n_d = 1'b0;
                if (fsm_cnt_q == SettleLast) begin
                    state_d   = HOLD;
                    fsm_cnt_d = '0;
                end else begin
                    fsm_cnt_d = fsm_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                soc_rst_n_d = 1'b0;
                if (btn_deb) begin
                    fsm_cnt_d = '0;
                end else if (fsm_cnt_q == HoldLast) begin
                    // sw_o here is the pre-edge value, so a change accepted this cycle is not latched.
                    latched_sw_d = sw_o;
                    soc_rst_n_d  = 1'b1;
                    state_d      = RUN;
                    fsm_cnt_d    = '0;
                end else begin
                    fsm_cnt_d = fsm_cnt_q + 1'b1;
                end
            end
            RUN: begin
                soc_rst_n_d = 1'b1;
                fsm_cnt_d   = '0;
                if (btn_deb) begin
                    soc_rst_n_d = 1'b0;
                    state_d     = HOLD;
                end
            end
            default: begin
                state_d     = INIT;
                fsm_cnt_d   = '0;
                soc_rst_n_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= INIT;
            fsm_cnt_q    <= '0;
            latched_sw_q <= '0;
            soc_rst_n_q  <= 1'b0;
            sw_changed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fsm_cnt_q    <= fsm_cnt_d;
            latched_sw_q <= latched_sw_d;
            soc_rst_n_q  <= soc_rst_n_d;
            sw_changed_q <= sw_changed_d;
        end
    end

    assign latched_sw_o = latched_sw_q;
    assign soc_rst_no   = soc_rst_n_q;
    assign sw_changed_o = sw_changed_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Self-checking bench for board_input_conditioner: directed scenarios with literal
// expectations, then random button/switch/reset activity checked against a window-based model.
module tb_board_input_conditioner;

    localparam int NumIn  = 4;
    localparam int S      = 2;
    localparam int D      = 8;
    localparam int R      = 4;
    localparam int NumCh  = NumIn + 1;
    localparam int Settle = S + D + 1;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             btn = 1'b0;
    logic [NumIn-1:0] sw_i = '0;
    logic [NumIn-1:0] sw_o;
    logic             sw_changed_o;
    logic [NumIn-1:0] latched_sw_o;
    logic             soc_rst_no;

    always #5 clk = ~clk;

    board_input_conditioner #(
        .NumIn         (NumIn),
        .SyncStages    (S),
        .DebounceCycles(D),
        .RstHoldCycles (R)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .btn_rst_i   (btn),
        .sw_i        (sw_i),
        .sw_o        (sw_o),
        .sw_changed_o(sw_changed_o),
        .latched_sw_o(latched_sw_o),
        .soc_rst_no  (soc_rst_no)
    );

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;
    bit model_live = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: input sample history per edge since reset release, evaluated by window rules.
    logic [NumCh-1:0] raw_hist[$];
    bit               btn_hist[$];
    logic [NumCh-1:0] deb_m;
    logic             soc_m;
    logic             chg_m;
    logic [NumIn-1:0] lat_m;

    // Value the debouncer compares at edge e: the input sampled S edges earlier, zero right after reset.
    function automatic logic synced(input int e, input int ch);
        if (e < S) return 1'b0;
        return raw_hist[e-S][ch];
    endfunction

    always @(posedge clk) begin
        if (!rst_ni) begin
            raw_hist.delete();
            btn_hist.delete();
            deb_m      = '0;
            soc_m      = 1'b0;
            chg_m      = 1'b0;
            lat_m      = '0;
            cyc        = 0;
            model_live = 1'b1;
        end else begin
            int n;
            logic [NumCh-1:0] new_deb;
            logic new_soc;
            raw_hist.push_back({btn, sw_i});
            btn_hist.push_back(deb_m[NumIn]);
            n = raw_hist.size() - 1;
            new_deb = deb_m;
            if (n - D + 1 >= 0) begin
                for (int ch = 0; ch < NumCh; ch++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    for (int j = 0; j < D; j++)
                        if (synced(n - j, ch) == deb_m[ch]) all_diff = 1'b0;
                    if (all_diff) new_deb[ch] = ~deb_m[ch];
                end
            end
            // SoC runs once the button has been seen released for R edges after settling.
            new_soc = 1'b0;
            if (n - R + 1 >= Settle) begin
                new_soc = 1'b1;
                for (int j = 0; j < R; j++)
                    if (btn_hist[n - j]) new_soc = 1'b0;
            end
            if (new_soc && !soc_m) lat_m = deb_m[NumIn-1:0];
            chg_m = (new_deb[NumIn-1:0] != deb_m[NumIn-1:0]);
            deb_m = new_deb;
            soc_m = new_soc;
            cyc   = cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("sw_o", 32'(sw_o), 32'(deb_m[NumIn-1:0]));
            check("sw_changed_o", 32'(sw_changed_o), 32'(chg_m));
            check("latched_sw_o", 32'(latched_sw_o), 32'(lat_m));
            check("soc_rst_no", 32'(soc_rst_no), 32'(soc_m));
        end
    end

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) check("wait_cyc_timeout", 32'(cyc), 32'(n));
    endtask

    initial begin
        int c0;
        int p;
        rst_ni = 1'b0;
        sw_i   = 4'b0110;
        btn    = 1'b0;
        repeat (3) @(negedge clk);

        // Scenario 1: power-up sequence
        rst_ni = 1'b1;
        wait_cyc(9);
        check("t1_sw_o_c9", 32'(sw_o), 32'h0);
        wait_cyc(10);
        check("t1_sw_o_c10", 32'(sw_o), 32'h6);
        wait_cyc(14);
        check("t1_soc_c14", 32'(soc_rst_no), 32'h0);
        wait_cyc(15);
        check("t1_soc_c15", 32'(soc_rst_no), 32'h1);
        check("t1_latched", 32'(latched_sw_o), 32'h6);
        check("t1_model_soc", 32'(soc_m), 32'h1);
        $display("scenario 1: power-up release, soc_rst_no=%0b latched=%b", soc_rst_no, latched_sw_o);

        // Scenario 2: 7-cycle glitch on sw_i[0] is rejected
        wait_cyc(20);
        sw_i[0] = 1'b1;
        repeat (7) @(negedge clk);
        sw_i[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t2_no_pulse", 32'(sw_changed_o), 32'h0);
            check("t2_sw_o", 32'(sw_o), 32'h6);
        end
        $display("scenario 2: short glitch, sw_o=%b", sw_o);

        // Scenario 3: clean switch edge
        c0 = cyc;
        sw_i[0] = 1'b1;
        wait_cyc(c0 + 9);
        check("t3_sw_o_before", 32'(sw_o), 32'h6);
        wait_cyc(c0 + 10);
        check("t3_sw_o_after", 32'(sw_o), 32'h7);
        check("t3_pulse", 32'(sw_changed_o), 32'h1);
        check("t3_latched", 32'(latched_sw_o), 32'h6);
        check("t3_model_sw", 32'(deb_m[NumIn-1:0]), 32'h7);
        wait_cyc(c0 + 11);
        check("t3_pulse_end", 32'(sw_changed_o), 32'h0);
        check("t3_soc", 32'(soc_rst_no), 32'h1);
        $display("scenario 3: switch edge, sw_o=%b latched=%b", sw_o, latched_sw_o);

        // Scenario 4: button held 30 cycles
        repeat (5) @(negedge clk);
        p = cyc;
        btn = 1'b1;
        wait_cyc(p + 10);
        check("t4_soc_p10", 32'(soc_rst_no), 32'h1);
        wait_cyc(p + 11);
        check("t4_soc_p11", 32'(soc_rst_no), 32'h0);
        wait_cyc(p + 30);
        check("t4_soc_held", 32'(soc_rst_no), 32'h0);
        btn = 1'b0;
        wait_cyc(p + 43);
        check("t4_soc_p43", 32'(soc_rst_no), 32'h0);
        wait_cyc(p + 44);
        check("t4_soc_p44", 32'(soc_rst_no), 32'h1);
        check("t4_latched", 32'(latched_sw_o), 32'h7);
        $display("scenario 4: button reset, latched=%b", latched_sw_o);

        // Scenario 5: bouncing button never resets the SoC
        repeat (3) @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            if (i % 3 == 0) btn = ~btn;
            @(negedge clk);
            check("t5_soc", 32'(soc_rst_no), 32'h1);
        end
        btn = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_soc_end", 32'(soc_rst_no), 32'h1);
        $display("scenario 5: bouncing button, soc_rst_no=%0b", soc_rst_no);

        // Scenario 6: one-cycle reset during HOLD restarts the sequence
        sw_i   = 4'b0110;
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        wait_cyc(12);
        rst_ni = 1'b0;
        @(negedge clk);
        check("t6_rst_sw_o", 32'(sw_o), 32'h0);
        check("t6_rst_latched", 32'(latched_sw_o), 32'h0);
        check("t6_rst_pulse", 32'(sw_changed_o), 32'h0);
        check("t6_rst_soc", 32'(soc_rst_no), 32'h0);
        rst_ni = 1'b1;
        wait_cyc(10);
        check("t6_sw_o_c10", 32'(sw_o), 32'h6);
        wait_cyc(14);
        check("t6_soc_c14", 32'(soc_rst_no), 32'h0);
        wait_cyc(15);
        check("t6_soc_c15", 32'(soc_rst_no), 32'h1);
        check("t6_latched", 32'(latched_sw_o), 32'h6);
        $display("scenario 6: reset in HOLD, soc_rst_no=%0b latched=%b", soc_rst_no, latched_sw_o);

        // Random activity against the model
        for (int k = 0; k < 150; k++) begin
            int r;
            int idx;
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                rst_ni = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_ni = 1'b1;
            end else if (r < 20) begin
                btn = 1'b1;
                repeat ($urandom_range(1, 25)) @(negedge clk);
                btn = 1'b0;
            end else if (r < 70) begin
                idx = int'($urandom_range(0, NumIn - 1));
                sw_i[idx] = ~sw_i[idx];
            end else begin
                sw_i = 4'($urandom);
            end
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        btn = 1'b0;
        repeat (40) @(negedge clk);
        $display("random phase: done at cycle %0d", cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
